reg_file_sb: RTL and testbench

//  Parametrised multi-register file for the ID stage: NREGS x XLEN storage, two async read ports,
//  one sync write port. Adds a per-register busy scoreboard so the core can track writes that are

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file_scoreboard.sv | 46 ++++
 rtl/reg_file_sb.sv | 88 ++++++++
 tb/tb_reg_file_sb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and index type for the ID-stage register file with busy scoreboard.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits for in-flight writes, plus a registered count of busy entries.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic set_new;
    logic clr_hit;

    // A clear only counts if it actually drops a busy bit that the same-cycle issue does not re-take.
    always_comb begin
        set_new = issue_en && !busy[issue_addr];
        clr_hit = clr_en && busy[clr_addr] && !(issue_en && (issue_addr == clr_addr));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (clr_en) begin
                busy[clr_addr] <= 1'b0;
            end
            if (issue_en) begin
                busy[issue_addr] <= 1'b1;
            end
            case ({set_new, clr_hit})
                2'b10:   busy_cnt <= busy_cnt + {{AW{1'b0}}, 1'b1};
                2'b01:   busy_cnt <= busy_cnt - {{AW{1'b0}}, 1'b1};
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// NREGS x XLEN register file, two async read ports, one write port, busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data/busy-clear onto the read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             issue_ok;
    logic             wr_ok;

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));
    endfunction

    // The hardwired zero register never reaches storage or the scoreboard.
    always_comb begin
        issue_ok = issue_en && !is_zero(issue_addr);
        wr_ok    = wr_en && !is_zero(wr_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_file_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_ok),
        .issue_addr (issue_addr),
        .clr_en     (wr_ok),
        .clr_addr   (wr_addr),
        .busy       (busy),
        .busy_cnt   (busy_cnt)
    );

`ifdef REG_FILE_BYPASS_EN
    logic byp1;
    logic byp2;

    // Forwarding looks only at the writeback; a same-cycle issue does not mask it.
    always_comb begin
        byp1     = wr_ok && (wr_addr == rs1_addr);
        byp2     = wr_ok && (wr_addr == rs2_addr);
        rs1_data = is_zero(rs1_addr) ? '0 : (byp1 ? wr_data : regs[rs1_addr]);
        rs2_data = is_zero(rs2_addr) ? '0 : (byp2 ? wr_data : regs[rs2_addr]);
        rs1_busy = busy[rs1_addr] & ~byp1;
        rs2_busy = busy[rs2_addr] & ~byp2;
    end
`else
    always_comb begin
        rs1_data = is_zero(rs1_addr) ? '0 : regs[rs1_addr];
        rs2_data = is_zero(rs2_addr) ? '0 : regs[rs2_addr];
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: behavioural array model, per-cycle compare, directed pins.
module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, issue_addr, wr_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, issue_en, wr_en;
    logic [5:0]  busy_cnt;

    logic [2:0]  s_rs1_addr, s_rs2_addr, s_issue_addr, s_wr_addr;
    logic [63:0] s_rs1_data, s_rs2_data, s_wr_data;
    logic        s_rs1_busy, s_rs2_busy, s_issue_en, s_wr_en;
    logic [3:0]  s_busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    logic [63:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.XLEN(64), .NREGS(8), .ZERO_REG(1)) u_small (
        .clk(clk), .reset(reset),
        .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
        .rs1_busy(s_rs1_busy), .rs2_busy(s_rs2_busy),
        .issue_en(s_issue_en), .issue_addr(s_issue_addr),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .busy_cnt(s_busy_cnt)
    );

    // Behavioural model of the large instance: plain arrays updated by the rules.
    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] <= wr_data;
                m_busy[wr_addr] <= 1'b0;
            end
            if (issue_en && issue_addr != 0) begin
                m_busy[issue_addr] <= 1'b1;
            end
        end
    end

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] model_data(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && reset) begin
            check("rs1_data", 64'(rs1_data), 64'(model_data(rs1_addr)));
            check("rs2_data", 64'(rs2_data), 64'(model_data(rs2_addr)));
            check("rs1_busy", 64'(rs1_busy), 64'(model_busy(rs1_addr)));
            check("rs2_busy", 64'(rs2_busy), 64'(model_busy(rs2_addr)));
            check("busy_cnt", 64'(busy_cnt), 64'(model_count()));
        end
    end

    task automatic drive(input logic ie, input logic [4:0] ia, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        issue_en = ie; issue_addr = ia;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rs1_addr = r1; rs2_addr = r2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        s_issue_en = 0; s_issue_addr = 0; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0;
        s_rs1_addr = 0; s_rs2_addr = 0;
        #2 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        started = 1;
        @(negedge clk);
        check("reset_cnt", 64'(busy_cnt), 64'd0);

        // Write then read r5 on both ports.
        step();
        drive(0, 0, 1, 5, 32'hDEADBEEF, 5, 5);
`ifdef REG_FILE_BYPASS_EN
        @(negedge clk);
        check("bypass_rs1", 64'(rs1_data), 64'hDEADBEEF);
`endif
        step();
        drive(0, 0, 0, 0, 0, 5, 5);
        @(negedge clk);
        check("wr_rd_rs1", 64'(rs1_data), 64'hDEADBEEF);
        check("wr_rd_rs2", 64'(rs2_data), 64'hDEADBEEF);

        // Zero register ignores issue and write.
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0, 32'h1234, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("zero_data", 64'(rs1_data), 64'd0);
        check("zero_busy", 64'(rs1_busy), 64'd0);
        check("zero_cnt", 64'(busy_cnt), 64'd0);

        // Scoreboard count sequence 1, 2, 1.
        step();
        drive(1, 3, 0, 0, 0, 0, 0);
        step();
        drive(1, 9, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sb_cnt1", 64'(busy_cnt), 64'd1);
        step();
        drive(0, 0, 1, 3, 32'h11, 0, 0);
        @(negedge clk);
        check("sb_cnt2", 64'(busy_cnt), 64'd2);
        step();
        drive(0, 0, 0, 0, 0, 9, 3);
        @(negedge clk);
        check("sb_cnt3", 64'(busy_cnt), 64'd1);
        check("sb_busy_r9", 64'(rs1_busy), 64'd1);
        check("sb_busy_r3", 64'(rs2_busy), 64'd0);
        check("sb_data_r3", 64'(rs2_data), 64'h11);

        // Same-cycle issue and write to r4: data lands, issue wins.
        step();
        drive(1, 4, 1, 4, 32'hAA, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 4, 4);
        @(negedge clk);
        check("col_data", 64'(rs1_data), 64'hAA);
        check("col_busy", 64'(rs1_busy), 64'd1);
        check("col_cnt", 64'(busy_cnt), 64'd2);

        // Asynchronous reset mid-run with r5 and r7 in flight.
        step();
        drive(1, 5, 0, 0, 0, 5, 7);
        step();
        drive(1, 7, 0, 0, 0, 5, 7);
        step();
        drive(0, 0, 0, 0, 0, 5, 7);
        #2 reset = 1'b0;
        #1;
        check("rst_async_cnt", 64'(busy_cnt), 64'd0);
        check("rst_async_busy", 64'(rs2_busy), 64'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rst_data", 64'(rs1_data), 64'd0);
        check("rst_busy1", 64'(rs1_busy), 64'd0);
        check("rst_busy2", 64'(rs2_busy), 64'd0);
        check("rst_cnt", 64'(busy_cnt), 64'd0);

        // Small 64-bit x 8 instance: write all entries, read back, fill busy.
        for (int i = 0; i < 8; i++) begin
            step();
            s_wr_en = 1; s_wr_addr = 3'(i);
            s_wr_data = {32'hA5A50000 + 32'(i), 32'h5A5A0000 + 32'(i)};
            exp_q.push_back((i == 0) ? 64'd0 : s_wr_data);
        end
        step();
        s_wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            s_rs1_addr = 3'(i);
            s_rs2_addr = 3'(i);
            @(negedge clk);
            check("small_rd1", s_rs1_data, exp_q[0]);
            check("small_rd2", s_rs2_data, exp_q.pop_front());
            step();
        end
        for (int i = 0; i < 8; i++) begin
            s_issue_en = 1; s_issue_addr = 3'(i);
            step();
        end
        s_issue_en = 1; s_issue_addr = 3;
        s_rs1_addr = 1; s_rs2_addr = 0;
        @(negedge clk);
        check("small_cnt_full", 64'(s_busy_cnt), 64'd7);
        check("small_busy_r1", 64'(s_rs1_busy), 64'd1);
        check("small_busy_r0", 64'(s_rs2_busy), 64'd0);
        step();
        s_issue_en = 0;
        @(negedge clk);
        check("small_cnt_reissue", 64'(s_busy_cnt), 64'd7);

        // Randomised traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) begin
                drive(0, 0, 0, 0, 0, 0, 0);
                #2 reset = 1'b0;
                step();
                step();
                reset = 1'b1;
            end else begin
                drive(($urandom_range(0, 99) < 40), pick_addr(),
                      ($urandom_range(0, 99) < 40), pick_addr(), $urandom(),
                      pick_addr(), pick_addr());
                if ($urandom_range(0, 3) == 0) rs1_addr = wr_addr;
                if ($urandom_range(0, 3) == 0) issue_addr = wr_addr;
            end
        end
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
